// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable serial pattern detector: windowed matching, hit/bit counting, result handshake.
// Optional idle timeout is built only when SEQ_CTRL_TIMEOUT_EN is defined.
module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 16,
  parameter int CNT_W = 8,
  parameter int TMO_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [PAT_W-1:0] i_mask,
  input  logic [LEN_W-1:0] i_win_len,
  input  logic [CNT_W-1:0] i_max_hits,
  input  logic [TMO_W-1:0] i_tmo_len,
  input  logic             i_abort,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  output logic             o_busy,
  output logic             o_hit,
  output logic             o_done_valid,
  input  logic             i_done_ready,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [LEN_W-1:0] o_bit_cnt,
  output logic [1:0]       o_status,
  output logic [1:0]       o_dbg_state
);

  // Result handshake: o_done_valid stays high with stable result fields until
  // the cycle o_done_valid & i_done_ready is sampled on a rising edge.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  localparam logic [1:0] ST_LEN   = 2'b00;
  localparam logic [1:0] ST_HITS  = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b11;

  state_t             state_q, state_d;
  logic [1:0]         status_d;
  logic [PAT_W-1:0]   sh_q, sh_nx;
  logic [FILL_W-1:0]  fill_q, fill_inc;
  logic [PAT_W-1:0]   pat_q, mask_q;
  logic [LEN_W-1:0]   win_q, bit_inc;
  logic [CNT_W-1:0]   max_q, hit_inc;
  logic               match;
  logic               consume;
  logic               start_ok;
  logic               timeout;

  assign start_ok = (state_q == S_IDLE) && i_start;
  // An abort discards the bit presented in the same cycle.
  assign consume  = (state_q == S_RUN) && i_bit_valid && !i_abort;

  assign sh_nx    = {sh_q[PAT_W-2:0], i_bit};
  assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign match    = (fill_inc == FILL_FULL) && (((sh_nx ^ pat_q) & mask_q) == '0);
  assign bit_inc  = o_bit_cnt + LEN_W'(1);
  assign hit_inc  = (match && (o_hit_cnt != '1)) ? o_hit_cnt + CNT_W'(1) : o_hit_cnt;

`ifdef SEQ_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, idle_q, idle_inc;

  assign idle_inc = idle_q + TMO_W'(1);
  assign timeout  = (state_q == S_RUN) && !i_bit_valid && (tmo_q != '0) && (idle_inc == tmo_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_q  <= '0;
      idle_q <= '0;
    end else if (start_ok) begin
      tmo_q  <= i_tmo_len;
      idle_q <= '0;
    end else if (state_q == S_RUN) begin
      idle_q <= i_bit_valid ? '0 : idle_inc;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^i_tmo_len;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    status_d = o_status;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = (i_win_len == '0) ? S_DONE : S_RUN;
          status_d = ST_LEN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (timeout) begin
          state_d  = S_DONE;
          status_d = ST_TMO;
        end else if (consume && (max_q != '0) && (hit_inc == max_q)) begin
          state_d  = S_DONE;
          status_d = ST_HITS;
        end else if (consume && (bit_inc == win_q)) begin
          state_d  = S_DONE;
          status_d = ST_LEN;
        end
      end
      S_DONE: begin
        if (i_done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      o_status     <= '0;
      o_busy       <= 1'b0;
      o_done_valid <= 1'b0;
      o_hit        <= 1'b0;
      sh_q         <= '0;
      fill_q       <= '0;
      pat_q        <= '0;
      mask_q       <= '0;
      win_q        <= '0;
      max_q        <= '0;
      o_bit_cnt    <= '0;
      o_hit_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      o_status     <= status_d;
      o_busy       <= (state_d == S_RUN);
      o_done_valid <= (state_d == S_DONE);
      o_hit        <= consume && match;
      if (start_ok) begin
        pat_q     <= i_pattern;
        mask_q    <= i_mask;
        win_q     <= i_win_len;
        max_q     <= i_max_hits;
        sh_q      <= '0;
        fill_q    <= '0;
        o_bit_cnt <= '0;
        o_hit_cnt <= '0;
      end else if (consume) begin
        sh_q      <= sh_nx;
        fill_q    <= fill_inc;
        o_bit_cnt <= bit_inc;
        o_hit_cnt <= hit_inc;
      end
    end
  end

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: drivers push expected results, a negedge monitor checks each handshake.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 4;
  localparam int LEN_W = 16;
  localparam int CNT_W = 8;
  localparam int TMO_W = 8;
  localparam int W     = 8 + CNT_W + LEN_W + 2;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic [PAT_W-1:0] i_pattern = '0;
  logic [PAT_W-1:0] i_mask = '0;
  logic [LEN_W-1:0] i_win_len = '0;
  logic [CNT_W-1:0] i_max_hits = '0;
  logic [TMO_W-1:0] i_tmo_len = '0;
  logic             i_abort = 1'b0;
  logic             i_bit_valid = 1'b0;
  logic             i_bit = 1'b0;
  logic             i_done_ready = 1'b1;
  logic             o_busy, o_hit, o_done_valid;
  logic [CNT_W-1:0] o_hit_cnt;
  logic [LEN_W-1:0] o_bit_cnt;
  logic [1:0]       o_status, o_dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int hit_seen = 0;

  seq_detect_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_pattern(i_pattern),
    .i_mask(i_mask), .i_win_len(i_win_len), .i_max_hits(i_max_hits),
    .i_tmo_len(i_tmo_len), .i_abort(i_abort), .i_bit_valid(i_bit_valid),
    .i_bit(i_bit), .o_busy(o_busy), .o_hit(o_hit), .o_done_valid(o_done_valid),
    .i_done_ready(i_done_ready), .o_hit_cnt(o_hit_cnt), .o_bit_cnt(o_bit_cnt),
    .o_status(o_status), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_cmd(input logic [PAT_W-1:0] pat, input logic [PAT_W-1:0] msk,
                           input logic [LEN_W-1:0] win, input logic [CNT_W-1:0] maxh,
                           input logic [TMO_W-1:0] tmo);
    i_start    = 1'b1;
    i_pattern  = pat;
    i_mask     = msk;
    i_win_len  = win;
    i_max_hits = maxh;
    i_tmo_len  = tmo;
    tick();
    i_start    = 1'b0;
    i_pattern  = PAT_W'($urandom_range(0, 15));
    i_mask     = PAT_W'($urandom_range(0, 15));
    i_win_len  = LEN_W'($urandom_range(1, 3));
    i_max_hits = CNT_W'($urandom_range(1, 3));
    i_tmo_len  = TMO_W'($urandom_range(1, 2));
  endtask

  task automatic send_bit(input logic b, input logic exp_hit, input string name);
    i_bit_valid = 1'b1;
    i_bit       = b;
    tick();
    i_bit_valid = 1'b0;
    check(name, 64'(o_hit), 64'(exp_hit));
  endtask

  task automatic push_exp(input int hits, input int hcnt, input int bcnt, input logic [1:0] st);
    exp_q.push_back({8'(hits), CNT_W'(hcnt), LEN_W'(bcnt), st});
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    logic [W-1:0] e;
    if (i_rst) begin
      hit_seen = 0;
    end else begin
      if (o_hit) hit_seen++;
      if (o_done_valid && i_done_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(o_status), 64'hff);
        end else begin
          e = exp_q.pop_front();
          check("res_hit_pulses", 64'(hit_seen), 64'(e[W-1 -: 8]));
          check("res_hit_cnt", 64'(o_hit_cnt), 64'(e[LEN_W+2 +: CNT_W]));
          check("res_bit_cnt", 64'(o_bit_cnt), 64'(e[2 +: LEN_W]));
          check("res_status", 64'(o_status), 64'(e[1:0]));
        end
        hit_seen = 0;
      end
    end
  end

  initial begin
    logic [6:0]  s1;
    logic [11:0] s2;
    s1 = 7'b1011011;
    s2 = 12'b1111_0000_1111;

    repeat (3) tick();
    check("rst_busy", 64'(o_busy), 0);
    check("rst_done", 64'(o_done_valid), 0);
    check("rst_counts", 64'({o_hit, o_hit_cnt, o_bit_cnt, o_status}), 0);
    check("rst_state", 64'(o_dbg_state), 0);
    i_rst = 1'b0;
    tick();

    // overlapping matches, length close
    push_exp(2, 2, 7, 2'b00);
    start_cmd(4'b1011, 4'b1111, 16'd7, 8'd0, 8'd0);
    check("t1_busy", 64'(o_busy), 1);
    for (int i = 0; i < 7; i++) send_bit(s1[6-i], (i == 3) || (i == 6), "t1_hit");
    check("t1_done_latency", 64'(o_done_valid), 1);
    tick();
    check("t1_idle", 64'(o_done_valid | o_busy), 0);

    // masked pattern, hit limit, trailing bits ignored
    push_exp(2, 2, 12, 2'b01);
    start_cmd(4'b1001, 4'b1001, 16'd20, 8'd2, 8'd0);
    for (int i = 0; i < 12; i++) send_bit(s2[11-i], (i == 3) || (i == 11), "t2_hit");
    check("t2_done", 64'(o_done_valid), 1);
    send_bit(1'b1, 1'b0, "t2_post_hit");
    send_bit(1'b1, 1'b0, "t2_post_hit");
    check("t2_bit_cnt_frozen", 64'(o_bit_cnt), 12);

    // zero-length window with back-pressure
    i_done_ready = 1'b0;
    start_cmd(4'b0000, 4'b1111, 16'd0, 8'd0, 8'd0);
    check("t3_done", 64'(o_done_valid), 1);
    check("t3_busy", 64'(o_busy), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold", 64'({o_done_valid, o_hit_cnt, o_bit_cnt, o_status}), 64'({1'b1, 26'd0}));
    end
    push_exp(0, 0, 0, 2'b00);
    i_done_ready = 1'b1;
    tick();
    check("t3_idle", 64'(o_done_valid), 0);
    check("t3_state", 64'(o_dbg_state), 0);

    // abort with a coincident valid bit; starts ignored in RUN and DONE
    start_cmd(4'b1011, 4'b1111, 16'd20, 8'd0, 8'd0);
    send_bit(1'b1, 1'b0, "t4_hit");
    i_start = 1'b1;
    i_win_len = 16'd0;
    send_bit(1'b1, 1'b0, "t4_hit");
    i_start = 1'b0;
    send_bit(1'b1, 1'b0, "t4_hit");
    check("t4_busy", 64'(o_busy), 1);
    i_done_ready = 1'b0;
    i_abort = 1'b1;
    send_bit(1'b1, 1'b0, "t4_abort_hit");
    i_abort = 1'b0;
    check("t4_abort_bits", 64'(o_bit_cnt), 3);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("t4_done_hold", 64'({o_done_valid, o_busy, o_status}), 64'(4'b1010));
    push_exp(0, 0, 3, 2'b10);
    i_done_ready = 1'b1;
    tick();
    check("t4_idle", 64'(o_done_valid), 0);

    // asynchronous reset mid-RUN and mid-DONE
    start_cmd(4'b1111, 4'b1111, 16'd10, 8'd0, 8'd0);
    send_bit(1'b0, 1'b0, "t5_hit");
    send_bit(1'b0, 1'b0, "t5_hit");
    check("t5_pre_bits", 64'(o_bit_cnt), 2);
    i_rst = 1'b1;
    #1;
    check("t5_run_rst", 64'({o_busy, o_bit_cnt, o_dbg_state}), 0);
    tick();
    i_rst = 1'b0;
    i_done_ready = 1'b0;
    start_cmd(4'b0000, 4'b1111, 16'd0, 8'd0, 8'd0);
    check("t5_done", 64'(o_done_valid), 1);
    i_rst = 1'b1;
    #1;
    check("t5_done_rst", 64'({o_done_valid, o_dbg_state}), 0);
    tick();
    i_rst = 1'b0;
    i_done_ready = 1'b1;
    push_exp(2, 2, 5, 2'b00);
    start_cmd(4'b0101, 4'b0000, 16'd5, 8'd0, 8'd0);
    for (int i = 0; i < 5; i++) send_bit(i[0], i >= 3, "t5_dc_hit");
    check("t5_done_after", 64'(o_done_valid), 1);
    tick();

    // idle timeout
    start_cmd(4'b1111, 4'b1111, 16'd20, 8'd0, 8'd4);
    send_bit(1'b1, 1'b0, "t6_hit");
    repeat (3) tick();
    check("t6_busy_3idle", 64'(o_busy), 1);
`ifdef SEQ_CTRL_TIMEOUT_EN
    push_exp(0, 0, 1, 2'b11);
    tick();
    check("t6_timeout", 64'({o_done_valid, o_status}), 64'(3'b111));
    tick();
`else
    tick();
    check("t6_no_timeout", 64'({o_busy, o_done_valid}), 64'(2'b10));
    repeat (4) tick();
    check("t6_still_run", 64'(o_busy), 1);
    push_exp(0, 0, 1, 2'b10);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    tick();
`endif

    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
